ifetch_ctrl: RTL and testbench

Instruction-fetch controller sitting between the PC/branch logic and the instruction memory. It sequences word fetches from the instruction memory and buffers the returned instructions with their PCs in a small prefetch queue. It presents them to the IF/ID stage with a valid/ready handshake. Branch and jump redirects flush the queue and discard any in-flight memory response.

---
 rtl/ifetch_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch controller between PC/branch logic and the
// instruction memory. It issues word fetches (at most one outstanding),
// buffers returned instructions with their PCs in a QDEPTH-entry FIFO, and
// presents the head to IF/ID with a valid/ready handshake. REDIRECT flushes
// the queue and discards any in-flight memory response.
//
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   IMEM_REQ, IMEM_ADDR     fetch request strobe and word-aligned byte address
//   IMEM_RVALID, IMEM_RDATA memory response (one or more cycles after request)
//   REDIRECT, REDIRECT_PC   taken branch/jump from EX and its target
//   IF_VALID/IF_INSTR/IF_PC registered queue head towards decode
//   ID_READY                decode accepts the head
//   IF_MISALIGN             head is a misaligned-target trap entry
//                           (only with IFETCH_MISALIGN_TRAP_EN defined)
//
// Build option: define IFETCH_MISALIGN_TRAP_EN to turn a misaligned redirect
// into a single trap entry and halt fetching until the next redirect. When it
// is undefined, REDIRECT_PC[1:0] is treated as zero.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output logic        IF_MISALIGN,
`endif
    input  logic        ID_READY
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    ptr_t        rd_q, rd_d, wr_q, wr_d, wr_slot;
    cnt_t        cnt_q, cnt_d, cnt_after;
    logic        valid_q, valid_d;
    logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
    logic [31:0] pc_mem_q    [QDEPTH];
    logic [31:0] instr_mem_q [QDEPTH];

    logic        push, pop, issue, fetch_en, wr_en;
    logic [31:0] push_pc, push_instr, redirect_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        halt_q, halt_d, mis_q, mis_d, trap;
    assign trap        = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
    assign fetch_en    = !halt_q;
    assign IF_MISALIGN = mis_q;
`else
    assign fetch_en    = 1'b1;
`endif

    assign redirect_tgt = REDIRECT_PC & 32'hFFFF_FFFC;

    // The request is a function of the current state and IMEM_RVALID so a
    // new fetch can leave in the same cycle the previous word returns; this
    // is what sustains one instruction per cycle with a 1-cycle memory.
    // The slot check uses the occupancy after this cycle's push/pop, so the
    // outstanding request always has a free entry waiting for it.
    always_comb begin
        push      = (state_q == S_WAIT) && IMEM_RVALID && !REDIRECT;
        pop       = valid_q && ID_READY;
        cnt_after = cnt_q + cnt_t'(push) - cnt_t'(pop);
        issue     = ((state_q == S_FETCH) || ((state_q == S_WAIT) && IMEM_RVALID))
                    && !REDIRECT && fetch_en && (cnt_after < cnt_t'(QDEPTH));
    end

    assign IMEM_REQ  = issue;
    assign IMEM_ADDR = issue ? fetch_pc_q : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        rd_d       = pop  ? rd_q + ptr_t'(1) : rd_q;
        wr_d       = push ? wr_q + ptr_t'(1) : wr_q;
        cnt_d      = cnt_after;
        wr_en      = push;
        wr_slot    = wr_q;
        push_pc    = req_addr_q;
        push_instr = IMEM_RDATA;

        if (issue) begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (issue) state_d = S_WAIT;
            S_WAIT:  if (IMEM_RVALID) state_d = issue ? S_WAIT : S_FETCH;
            S_DRAIN: if (IMEM_RVALID) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // Flush overrides everything; an accepted pop is simply subsumed.
        if (REDIRECT) begin
            fetch_pc_d = redirect_tgt;
            rd_d       = '0;
            wr_d       = '0;
            cnt_d      = '0;
            wr_en      = 1'b0;
            state_d    = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !IMEM_RVALID)
                         ? S_DRAIN : S_FETCH;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (trap) begin
                wr_en      = 1'b1;
                wr_slot    = '0;
                wr_d       = ptr_t'(1);
                cnt_d      = cnt_t'(1);
                push_pc    = REDIRECT_PC;
                push_instr = 32'h0000_0013;
            end
`endif
        end

        // Head registers are loaded from the post-update queue; an entry
        // written this cycle into the head slot is taken from the write data.
        valid_d = (cnt_d != '0);
        if (!valid_d) begin
            head_pc_d    = '0;
            head_instr_d = '0;
        end else if (wr_en && (wr_slot == rd_d)) begin
            head_pc_d    = push_pc;
            head_instr_d = push_instr;
        end else begin
            head_pc_d    = pc_mem_q[rd_d];
            head_instr_d = instr_mem_q[rd_d];
        end

`ifdef IFETCH_MISALIGN_TRAP_EN
        halt_d = REDIRECT ? trap : halt_q;
        mis_d  = REDIRECT ? trap : (pop ? 1'b0 : mis_q);
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_q       <= 1'b0;
            mis_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
            halt_q       <= halt_d;
            mis_q        <= mis_d;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem_q[wr_slot]    <= push_pc;
            instr_mem_q[wr_slot] <= push_instr;
        end
    end

    assign IF_VALID = valid_q;
    assign IF_PC    = head_pc_q;
    assign IF_INSTR = head_instr_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
module tb_ifetch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        ID_READY;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        IF_MISALIGN;
`endif

    ifetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .IF_VALID    (IF_VALID),
        .IF_INSTR    (IF_INSTR),
        .IF_PC       (IF_PC),
`ifdef IFETCH_MISALIGN_TRAP_EN
        .IF_MISALIGN (IF_MISALIGN),
`endif
        .ID_READY    (ID_READY)
    );

    always #5 CLK = ~CLK;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    // memory model state and next-cycle stimulus
    logic        req_seen  = 1'b0;
    logic [31:0] addr_seen = '0;
    logic        pend      = 1'b0;
    int          pend_left = 0;
    logic [31:0] pend_addr = '0;
    int          lat       = 1;
    logic        nxt_rstn  = 1'b0;
    logic        nxt_redir = 1'b0;
    logic [31:0] nxt_rpc   = '0;
    logic        nxt_ready = 1'b1;
    int unsigned nreq;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // One clock: drive memory response and stimulus 1ns after the edge,
    // then sample at the falling edge (caller checks there).
    task automatic step();
        @(posedge CLK);
        #1;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = '0;
        if (req_seen) begin
            pend      = 1'b1;
            pend_left = lat;
            pend_addr = addr_seen;
        end
        if (pend) begin
            pend_left = pend_left - 1;
            if (pend_left <= 0) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = mdata(pend_addr);
                pend        = 1'b0;
            end
        end
        RESET_N     = nxt_rstn;
        REDIRECT    = nxt_redir;
        REDIRECT_PC = nxt_rpc;
        ID_READY    = nxt_ready;
        #4;
        req_seen  = IMEM_REQ;
        addr_seen = IMEM_ADDR;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        RESET_N     = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = '0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = '0;
        ID_READY    = 1'b1;

        // reset state
        step();
        step();
        chk("rst_req",   32'(IMEM_REQ), 32'd0);
        chk("rst_addr",  IMEM_ADDR,     32'd0);
        chk("rst_valid", 32'(IF_VALID), 32'd0);
        chk("rst_pc",    IF_PC,         32'd0);
        chk("rst_instr", IF_INSTR,      32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("rst_mis",   32'(IF_MISALIGN), 32'd0);
`endif

        // streaming fetch, 1-cycle memory, decode always ready
        nxt_rstn = 1'b1;
        step(); chk("c0_idle_req", 32'(IMEM_REQ), 32'd0);
        step(); chk("c1_req",      32'(IMEM_REQ), 32'd1);
                chk("c1_addr",     IMEM_ADDR,     32'h0);
        step(); chk("c2_addr",     IMEM_ADDR,     32'h4);
                chk("c2_nobypass", 32'(IF_VALID), 32'd0);
        step(); chk("c3_addr",     IMEM_ADDR,     32'h8);
                chk("c3_valid",    32'(IF_VALID), 32'd1);
                chk("c3_pc",       IF_PC,         32'h0);
                chk("c3_instr",    IF_INSTR,      32'hC0DE_0000);
        step(); chk("c4_pc",       IF_PC,         32'h4);
                chk("c4_instr",    IF_INSTR,      32'hC0DE_0004);
        step(); chk("c5_pc",       IF_PC,         32'h8);

        // redirect in the same cycle as a response
        nxt_redir = 1'b1; nxt_rpc = 32'h40;
        step(); chk("c6_redir_noreq", 32'(IMEM_REQ), 32'd0);
        nxt_redir = 1'b0;
        step(); chk("c7_req",      32'(IMEM_REQ), 32'd1);
                chk("c7_addr",     IMEM_ADDR,     32'h40);
                chk("c7_flushed",  32'(IF_VALID), 32'd0);
        step(); chk("c8_valid",    32'(IF_VALID), 32'd0);
        step(); chk("c9_valid",    32'(IF_VALID), 32'd1);
                chk("c9_pc",       IF_PC,         32'h40);
                chk("c9_instr",    IF_INSTR,      32'hC0DE_0040);

        // back-pressure: restart at 0 with decode stalled for 10 cycles
        nxt_redir = 1'b1; nxt_rpc = 32'h0; nxt_ready = 1'b0;
        step();
        nxt_redir = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (IMEM_REQ) nreq++;
        end
        chk("stall_req_count", nreq,          32'd4);
        chk("stall_valid",     32'(IF_VALID), 32'd1);
        chk("stall_pc_hold",   IF_PC,         32'h0);
        chk("stall_instr",     IF_INSTR,      32'hC0DE_0000);
        nxt_ready = 1'b1;
        step(); chk("drain_pc0",    IF_PC,    32'h0);
        step(); chk("drain_pc4",    IF_PC,    32'h4);
        step(); chk("drain_pc8",    IF_PC,    32'h8);
        step(); chk("drain_pcC",    IF_PC,    32'hC);
                chk("drain_instrC", IF_INSTR, 32'hC0DE_000C);
        step(); chk("drain_pc10",   IF_PC,    32'h10);

        // asynchronous reset pulse mid-fetch
        RESET_N = 1'b0;
        #1;
        chk("arst_req",   32'(IMEM_REQ), 32'd0);
        chk("arst_addr",  IMEM_ADDR,     32'd0);
        chk("arst_valid", 32'(IF_VALID), 32'd0);
        chk("arst_pc",    IF_PC,         32'd0);
        chk("arst_instr", IF_INSTR,      32'd0);
        step(); chk("r0_req",   32'(IMEM_REQ), 32'd0);
                chk("r0_valid", 32'(IF_VALID), 32'd0);
        step(); chk("r1_req",   32'(IMEM_REQ), 32'd1);
                chk("r1_addr",  IMEM_ADDR,     32'h0);
        step(); chk("r2_valid", 32'(IF_VALID), 32'd0);
        step(); chk("r3_pc",    IF_PC,         32'h0);
                chk("r3_instr", IF_INSTR,      32'hC0DE_0000);

        // 3-cycle memory; redirect while a request is outstanding
        lat = 3;
        step(); step(); step();
        nxt_redir = 1'b1; nxt_rpc = 32'h100;
        step(); chk("r7_req",      32'(IMEM_REQ), 32'd0);
        nxt_redir = 1'b0;
        step(); chk("r8_req",      32'(IMEM_REQ), 32'd0);
                chk("r8_flushed",  32'(IF_VALID), 32'd0);
        step(); chk("r9_drop_req", 32'(IMEM_REQ), 32'd0);
        step(); chk("r10_req",     32'(IMEM_REQ), 32'd1);
                chk("r10_addr",    IMEM_ADDR,     32'h100);
                chk("r10_nostale", 32'(IF_VALID), 32'd0);
        step(); step();
        step(); chk("r13_valid",   32'(IF_VALID), 32'd0);
        step(); chk("r14_valid",   32'(IF_VALID), 32'd1);
                chk("r14_pc",      IF_PC,         32'h100);
                chk("r14_instr",   IF_INSTR,      32'hC0DE_0100);

        // misaligned redirect target
        nxt_redir = 1'b1; nxt_rpc = 32'h102; nxt_ready = 1'b0;
        step();
        nxt_redir = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (IMEM_REQ) nreq++;
        end
        chk("mis_halt_req", nreq,             32'd0);
        chk("mis_valid",    32'(IF_VALID),    32'd1);
        chk("mis_pc",       IF_PC,            32'h102);
        chk("mis_instr",    IF_INSTR,         32'h0000_0013);
        chk("mis_flag",     32'(IF_MISALIGN), 32'd1);
        nxt_redir = 1'b1; nxt_rpc = 32'h200;
        step(); chk("mis_redir_req", 32'(IMEM_REQ), 32'd0);
        nxt_redir = 1'b0; nxt_ready = 1'b1;
        step(); chk("mis_resume_req",  32'(IMEM_REQ),    32'd1);
                chk("mis_resume_addr", IMEM_ADDR,        32'h200);
                chk("mis_cleared",     32'(IF_MISALIGN), 32'd0);
`else
        step(); chk("align_drop_req", 32'(IMEM_REQ), 32'd0);
        step(); chk("align_req",      32'(IMEM_REQ), 32'd1);
                chk("align_addr",     IMEM_ADDR,     32'h100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
